uart_rx_module: RTL

UART receiver with 16x oversampling. Sits directly downstream of the baud-rate generator and consumes its one-cycle max-tick pulse as `i_tick`. It deserialises the asynchronous `i_rx` line into NB_DATA-bit words, LSB first. Each good word is reported with a one-cycle `o_rx_done` pulse; a frame whose stop bit is bad is reported with a one-cycle `o_frame_err` pulse instead.

---
 rtl/uart_rx_module.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx_module.sv
// UART receiver, 16x oversampled: synchronises i_rx, finds the start bit, samples
// NB_DATA data bits LSB first, then reports a good word or a framing error.
module uart_rx_module #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic [1:0]         o_dbg_state
);

  localparam int NB_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [4:0]      S_MID      = 5'd7;
  localparam logic [4:0]      S_BIT_LAST = 5'd15;
  localparam logic [4:0]      S_STOP_END = 5'(SB_TICK - 1);
  localparam logic [NB_W-1:0] N_LAST     = NB_W'(NB_DATA - 1);

  // Encoding is visible on o_dbg_state: 0 idle, 1 start, 2 data, 3 stop.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic               rx_meta, rx_s;
  logic [4:0]         s, s_next;
  logic [NB_W-1:0]    n, n_next;
  logic [NB_DATA-1:0] b, b_next;
  logic               stop_flag, stop_next;
  logic [NB_DATA-1:0] data_next;
  logic               done_next, err_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= ST_IDLE;
      s           <= '0;
      n           <= '0;
      b           <= '0;
      stop_flag   <= 1'b0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_meta     <= i_rx;
      rx_s        <= rx_meta;
      state       <= state_next;
      s           <= s_next;
      n           <= n_next;
      b           <= b_next;
      stop_flag   <= stop_next;
      o_data      <= data_next;
      o_rx_done   <= done_next;
      o_frame_err <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    stop_next  = stop_flag;
    data_next  = o_data;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      // Start detection is not tick-aligned, so it reacts on any clock.
      ST_IDLE: begin
        if (!rx_s) begin
          state_next = ST_START;
          s_next     = '0;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_next = ST_DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (s == S_BIT_LAST) begin
            s_next = '0;
            b_next = {rx_s, b[NB_DATA-1:1]};
            if (n == N_LAST) state_next = ST_STOP;
            else             n_next     = n + 1'b1;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (i_tick) begin
          if (s == S_MID) stop_next = rx_s;
          if (s == S_STOP_END) begin
            state_next = ST_IDLE;
            if (stop_flag) begin
              data_next = b;
              done_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_dbg_state = state;

endmodule
